// File: rtl/mc_control.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with retire counter.
// Build with MC_CONTROL_JAL_EN defined to support jal (opcode 0x6F).
module mc_control #(
  parameter int MAX_INS = 43
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] ins,
  input  logic        zero,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSel,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic [7:0]  retired,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_BEQ, C_JAL, C_BAD
  } cls_t;

  state_t      state, nxt;
  cls_t        cls;
  logic [31:0] ir;
  logic [7:0]  cnt;
  logic [2:0]  dop;
  logic        dsrc;
  logic        done_q, ill_q;
  logic        irw, pcw, rw, mr, mw;
  logic        last;
  logic        unused_ir;

  assign unused_ir = ^{ir[24:15], ir[11:7]};
  assign last      = (cnt == 8'(MAX_INS - 1));

  // op/ALUSrc derive from IR only, so they hold until the next fetch
  always_comb begin
    cls  = C_BAD;
    dop  = 3'b010;
    dsrc = 1'b0;
    case (ir[6:0])
      7'h33: begin
        case ({ir[14:12], ir[31:25]})
          10'b111_0000000: begin cls = C_R; dop = 3'b000; end
          10'b110_0000000: begin cls = C_R; dop = 3'b001; end
          10'b000_0000000: begin cls = C_R; dop = 3'b010; end
          10'b000_0100000: begin cls = C_R; dop = 3'b110; end
          10'b010_0000000: begin cls = C_R; dop = 3'b111; end
          default: ;
        endcase
      end
      7'h13: begin
        case (ir[14:12])
          3'b111: begin cls = C_I; dop = 3'b000; dsrc = 1'b1; end
          3'b110: begin cls = C_I; dop = 3'b001; dsrc = 1'b1; end
          3'b000: begin cls = C_I; dop = 3'b010; dsrc = 1'b1; end
          3'b010: begin cls = C_I; dop = 3'b111; dsrc = 1'b1; end
          default: ;
        endcase
      end
      7'h03: begin cls = C_LD; dsrc = 1'b1; end
      7'h23: begin cls = C_ST; dsrc = 1'b1; end
      7'h63: begin cls = C_BEQ; dop = 3'b110; end
`ifdef MC_CONTROL_JAL_EN
      7'h6F: cls = C_JAL;
`endif
      default: ;
    endcase
  end

  always_comb begin
    nxt     = state;
    irw     = 1'b0;
    pcw     = 1'b0;
    rw      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    PCSel   = 2'd0;
    Mem2Reg = 1'b0;
    unique case (state)
      FETCH: begin
        if (run) begin
          irw = 1'b1;
          nxt = DECODE;
        end
      end
      DECODE: nxt = (cls == C_BAD) ? HALT : EXEC;
      EXEC: begin
        case (cls)
          C_BEQ: begin
            pcw   = 1'b1;
            PCSel = zero ? 2'd1 : 2'd0;
          end
`ifdef MC_CONTROL_JAL_EN
          C_JAL: begin
            pcw   = 1'b1;
            PCSel = 2'd2;
          end
`endif
          C_LD, C_ST: nxt = MEM;
          default:    nxt = WB;
        endcase
      end
      MEM: begin
        if (cls == C_LD) begin
          mr  = 1'b1;
          nxt = WB;
        end else begin
          mw  = 1'b1;
          pcw = 1'b1;
        end
      end
      WB: begin
        rw      = 1'b1;
        Mem2Reg = (cls == C_LD);
        pcw     = 1'b1;
      end
      HALT: nxt = HALT;
      default: nxt = FETCH;
    endcase
    if (pcw) nxt = last ? HALT : FETCH;
  end

  // a reset cycle must never let a write strobe through
  assign IRWrite  = irw & ~rst;
  assign PCWrite  = pcw & ~rst;
  assign RegWrite = rw & ~rst;
  assign MemRead  = mr & ~rst;
  assign MemWrite = mw & ~rst;
  assign op       = dop;
  assign ALUSrc   = dsrc;
  assign retired  = cnt;
  assign done     = done_q;
  assign illegal  = ill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      ir     <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (irw) ir <= ins;
      if (pcw) cnt <= cnt + 8'd1;
      if (pcw && last) done_q <= 1'b1;
      if (state == DECODE && cls == C_BAD) ill_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-cycle stimulus/expectation queue built
// from an independent model of the instruction paths.
module tb_mc_control;

  logic        clk, rst, run, zero;
  logic [31:0] ins;
  logic        IRWrite, PCWrite, RegWrite, ALUSrc;
  logic        Mem2Reg, MemRead, MemWrite, done, illegal;
  logic [1:0]  PCSel;
  logic [2:0]  op;
  logic [7:0]  retired;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    logic [11:0] e;
  } ent_t;

  ent_t       q[$];
  ent_t       it;
  logic [2:0] cur_op;
  logic       cur_src;

  mc_control #(.MAX_INS(3)) dut (
    .clk(clk), .rst(rst), .run(run), .ins(ins), .zero(zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Mem2Reg(Mem2Reg),
    .MemRead(MemRead), .MemWrite(MemWrite), .op(op),
    .retired(retired), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {IRWrite, PCWrite, PCSel, RegWrite, ALUSrc,
            Mem2Reg, MemRead, MemWrite, op};
  endfunction

  function automatic logic [11:0] ev(
    logic irw, logic pcw, logic [1:0] sel, logic rw,
    logic m2r, logic mr, logic mw, logic s, logic [2:0] o);
    return {irw, pcw, sel, rw, s, m2r, mr, mw, o};
  endfunction

  function automatic void push_fetch();
    q.push_back('{32'h0, 1'b0,
      ev(1, 0, 0, 0, 0, 0, 0, cur_src, cur_op)});
  endfunction

  // c: 0 R/I, 1 load, 2 store, 3 beq, 4 jal, -1 illegal
  function automatic void push_ins(logic [31:0] i, logic z);
    logic [2:0] o = 3'b010;
    logic       s = 1'b0;
    int         c = -1;
    case (i[6:0])
      7'h33: case ({i[14:12], i[31:25]})
        10'b111_0000000: begin c = 0; o = 3'b000; end
        10'b110_0000000: begin c = 0; o = 3'b001; end
        10'b000_0000000: begin c = 0; o = 3'b010; end
        10'b000_0100000: begin c = 0; o = 3'b110; end
        10'b010_0000000: begin c = 0; o = 3'b111; end
        default: c = -1;
      endcase
      7'h13: begin
        s = 1'b1;
        case (i[14:12])
          3'b111: begin c = 0; o = 3'b000; end
          3'b110: begin c = 0; o = 3'b001; end
          3'b000: begin c = 0; o = 3'b010; end
          3'b010: begin c = 0; o = 3'b111; end
          default: begin c = -1; s = 1'b0; end
        endcase
      end
      7'h03: begin c = 1; s = 1'b1; end
      7'h23: begin c = 2; s = 1'b1; end
      7'h63: begin c = 3; o = 3'b110; end
`ifdef MC_CONTROL_JAL_EN
      7'h6F: c = 4;
`endif
      default: c = -1;
    endcase
    q.push_back('{i, z, ev(1, 0, 0, 0, 0, 0, 0, cur_src, cur_op)});
    cur_op  = o;
    cur_src = s;
    q.push_back('{i, z, ev(0, 0, 0, 0, 0, 0, 0, s, o)});
    case (c)
      0: begin
        q.push_back('{i, z, ev(0, 0, 0, 0, 0, 0, 0, s, o)});
        q.push_back('{i, z, ev(0, 1, 0, 1, 0, 0, 0, s, o)});
      end
      1: begin
        q.push_back('{i, z, ev(0, 0, 0, 0, 0, 0, 0, s, o)});
        q.push_back('{i, z, ev(0, 0, 0, 0, 0, 1, 0, s, o)});
        q.push_back('{i, z, ev(0, 1, 0, 1, 1, 0, 0, s, o)});
      end
      2: begin
        q.push_back('{i, z, ev(0, 0, 0, 0, 0, 0, 0, s, o)});
        q.push_back('{i, z, ev(0, 1, 0, 0, 0, 0, 1, s, o)});
      end
      3: q.push_back('{i, z, ev(0, 1, {1'b0, z}, 0, 0, 0, 0, s, o)});
      4: q.push_back('{i, z, ev(0, 1, 2'd2, 0, 0, 0, 0, s, o)});
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    run  = 1'b0;
    zero = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    cur_op  = 3'b010;
    cur_src = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    ins = 32'h00118133;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obs() !== 12'h002) begin
      bad++;
      $display("FAIL reset_strobes got=%h want=002", obs());
    end
    total++;
    if ({retired, done, illegal} !== 10'd0) begin
      bad++;
      $display("FAIL reset_regs got=%h/%b/%b want=0/0/0",
               retired, done, illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    #1;
    total++;
    if (obs() !== 12'h002) begin
      bad++;
      $display("FAIL idle_fetch got=%h want=002", obs());
    end
    cur_op  = 3'b010;
    cur_src = 1'b0;
  endtask

  task automatic test_alu();
    logic [31:0] v[9] = '{32'h00118133, 32'h40118133, 32'h0011F133,
                          32'h0011E133, 32'h0011A133, 32'h00100093,
                          32'h00107093, 32'h00106093, 32'h00102093};
    foreach (v[n]) begin
      do_reset();
      push_ins(v[n], 1'b0);
      push_fetch();
      for (int k = 0; q.size() > 0; k++) begin
        it = q.pop_front();
        @(negedge clk);
        run  = 1'b1;
        ins  = it.ins;
        zero = it.z;
        #1;
        total++;
        if (obs() !== it.e) begin
          bad++;
          $display("FAIL alu %h cyc%0d got=%h want=%h",
                   v[n], k + 1, obs(), it.e);
        end
      end
      total++;
      if (retired !== 8'd1) begin
        bad++;
        $display("FAIL alu_ret %h got=%0d want=1", v[n], retired);
      end
    end
  endtask

  task automatic test_mem();
    logic [31:0] v[2] = '{32'h00002283, 32'h02802023};
    foreach (v[n]) begin
      do_reset();
      push_ins(v[n], 1'b0);
      push_fetch();
      for (int k = 0; q.size() > 0; k++) begin
        it = q.pop_front();
        @(negedge clk);
        run  = 1'b1;
        ins  = it.ins;
        zero = it.z;
        #1;
        total++;
        if (obs() !== it.e) begin
          bad++;
          $display("FAIL mem %h cyc%0d got=%h want=%h",
                   v[n], k + 1, obs(), it.e);
        end
      end
      total++;
      if (retired !== 8'd1) begin
        bad++;
        $display("FAIL mem_ret %h got=%0d want=1", v[n], retired);
      end
    end
  endtask

  task automatic test_beq();
    do_reset();
    push_ins(32'h00000063, 1'b1);
    push_ins(32'h00000063, 1'b0);
    push_fetch();
    for (int k = 0; q.size() > 0; k++) begin
      it = q.pop_front();
      @(negedge clk);
      run  = 1'b1;
      ins  = it.ins;
      zero = it.z;
      #1;
      total++;
      if (obs() !== it.e) begin
        bad++;
        $display("FAIL beq cyc%0d got=%h want=%h", k + 1, obs(), it.e);
      end
    end
    total++;
    if (retired !== 8'd2) begin
      bad++;
      $display("FAIL beq_ret got=%0d want=2", retired);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) push_ins(32'h00100093, 1'b0);
    q.push_back('{32'h00100093, 1'b0,
      ev(0, 0, 0, 0, 0, 0, 0, cur_src, cur_op)});
    q.push_back('{32'h00100093, 1'b0,
      ev(0, 0, 0, 0, 0, 0, 0, cur_src, cur_op)});
    for (int k = 0; q.size() > 0; k++) begin
      it = q.pop_front();
      @(negedge clk);
      run  = 1'b1;
      ins  = it.ins;
      zero = it.z;
      #1;
      total++;
      if (obs() !== it.e) begin
        bad++;
        $display("FAIL b2b cyc%0d got=%h want=%h", k + 1, obs(), it.e);
      end
    end
    total++;
    if ({done, illegal, retired} !== {1'b1, 1'b0, 8'd3}) begin
      bad++;
      $display("FAIL b2b_halt got=%b/%b/%0d want=1/0/3",
               done, illegal, retired);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    push_ins(32'h00100093, 1'b0);
    push_ins(32'h00100093, 1'b0);
    for (int k = 0; k < 6; k++) begin
      it = q.pop_front();
      @(negedge clk);
      run  = 1'b1;
      ins  = it.ins;
      zero = it.z;
      #1;
      total++;
      if (obs() !== it.e) begin
        bad++;
        $display("FAIL rstmid cyc%0d got=%h want=%h", k + 1, obs(), it.e);
      end
    end
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({RegWrite, PCWrite} !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_gate got=%b%b want=00", RegWrite, PCWrite);
    end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (obs() !== 12'h002 || retired !== 8'd0) begin
        bad++;
        $display("FAIL rstmid_after cyc%0d got=%h/%0d want=002/0",
                 k, obs(), retired);
      end
      @(negedge clk);
    end
    cur_op  = 3'b010;
    cur_src = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] v[3] = '{32'h0000007F, 32'h02118133, 32'h00101093};
    foreach (v[n]) begin
      do_reset();
      push_ins(v[n], 1'b0);
      q.push_back('{v[n], 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 3'b010)});
      for (int k = 0; q.size() > 0; k++) begin
        it = q.pop_front();
        @(negedge clk);
        run  = 1'b1;
        ins  = it.ins;
        zero = it.z;
        #1;
        total++;
        if (obs() !== it.e) begin
          bad++;
          $display("FAIL ill %h cyc%0d got=%h want=%h",
                   v[n], k + 1, obs(), it.e);
        end
      end
      total++;
      if ({illegal, done, retired} !== {1'b1, 1'b0, 8'd0}) begin
        bad++;
        $display("FAIL ill_flag %h got=%b/%b/%0d want=1/0/0",
                 v[n], illegal, done, retired);
      end
    end
    do_reset();
    #1;
    total++;
    if (illegal !== 1'b0) begin
      bad++;
      $display("FAIL ill_clear got=%b want=0", illegal);
    end
  endtask

  task automatic test_jal();
    do_reset();
    push_ins(32'h0000006F, 1'b0);
`ifdef MC_CONTROL_JAL_EN
    push_fetch();
`else
    q.push_back('{32'h6F, 1'b0, ev(0, 0, 0, 0, 0, 0, 0, 0, 3'b010)});
`endif
    for (int k = 0; q.size() > 0; k++) begin
      it = q.pop_front();
      @(negedge clk);
      run  = 1'b1;
      ins  = it.ins;
      zero = it.z;
      #1;
      total++;
      if (obs() !== it.e) begin
        bad++;
        $display("FAIL jal cyc%0d got=%h want=%h", k + 1, obs(), it.e);
      end
    end
`ifdef MC_CONTROL_JAL_EN
    total++;
    if ({illegal, retired} !== {1'b0, 8'd1}) begin
      bad++;
      $display("FAIL jal_ret got=%b/%0d want=0/1", illegal, retired);
    end
`else
    total++;
    if ({illegal, retired} !== {1'b1, 8'd0}) begin
      bad++;
      $display("FAIL jal_ill got=%b/%0d want=1/0", illegal, retired);
    end
`endif
  endtask

  initial begin
    rst     = 1'b0;
    run     = 1'b0;
    zero    = 1'b0;
    ins     = 32'h0;
    cur_op  = 3'b010;
    cur_src = 1'b0;
    test_reset();
    test_alu();
    test_mem();
    test_beq();
    test_back_to_back();
    test_rst_mid();
    test_illegal();
    test_jal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MAX_INS, default 43: number of instructions retired before the block halts.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 run  input  1  start/continue enable, sampled only in FETCH.
REQ-005 ins  input  32  instruction word from the fetch stage.
REQ-006 zero  input  1  ALU zero flag from the execute stage.
REQ-007 IRWrite  output  1  latch-instruction strobe.
REQ-008 PCWrite  output  1  PC update strobe.
REQ-009 PCSel  output  2  next-PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-010 RegWrite, ALUSrc, Mem2Reg, MemRead, MemWrite  output  1 each  datapath controls.
REQ-011 op  output  3  ALU operation code.
REQ-012 retired  output  8  count of instructions retired.
REQ-013 done  output  1  MAX_INS reached.
REQ-014 illegal  output  1  unsupported instruction encountered.

Function
REQ-015 States SHALL be FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016 FETCH with run=1: SHALL assert IRWrite, capture ins into an internal IR, and go to DECODE; FETCH with run=0: SHALL stay in FETCH with all strobes at 0.
REQ-017 DECODE SHALL classify IR[6:0] as R (0x33), I (0x13), load (0x03), store (0x23) or beq (0x63), then go to EXEC.
REQ-018 DECODE SHALL hold op and ALUSrc constant from DECODE until the instruction retires.
REQ-019 R-type op mapping SHALL be: and 000, or 001, add 010, sub 110, slt 111, using funct3/funct7 {111/0, 110/0, 000/0, 000/0x20, 010/0}.
REQ-020 I-type op mapping SHALL be andi 000, ori 001, addi 010, slti 111, selected by funct3; ALUSrc SHALL be 1.
REQ-021 Load and store SHALL use op=010 and ALUSrc=1; beq SHALL use op=110 and ALUSrc=0; R-type SHALL use ALUSrc=0.
REQ-022 Paths SHALL be: R/I FETCH-DECODE-EXEC-WB (4 cycles); load FETCH-DECODE-EXEC-MEM-WB (5 cycles); store FETCH-DECODE-EXEC-MEM (4 cycles); beq FETCH-DECODE-EXEC (3 cycles).
REQ-023 MemRead SHALL be 1 only in MEM for a load, and MemWrite SHALL be 1 only in MEM for a store.
REQ-024 RegWrite SHALL be 1 only in WB; Mem2Reg SHALL be 1 in WB for a load and 0 otherwise.
REQ-025 PCWrite SHALL pulse for exactly one cycle in the final state of each instruction.
REQ-026 PCSel on the PCWrite pulse SHALL be 1 for beq with zero=1 (zero sampled in EXEC), and 0 for every other case.
REQ-027 retired SHALL increment on each PCWrite.
REQ-028 When retired reaches MAX_INS, the next state SHALL be HALT with done=1; HALT SHALL be held until rst.
REQ-029 An unmatched opcode or R/I funct SHALL cause DECODE to go to HALT with illegal=1, no PCWrite, and no increment of retired.
REQ-030 In HALT, all strobes SHALL be 0.

Reset
REQ-031 rst=1 SHALL force, on the next edge: state FETCH, all strobes 0, PCSel=0, op=010, ALUSrc=0, Mem2Reg=0, retired=0, done=0, illegal=0, IR=0.
REQ-032 rst SHALL take priority over every transition, including mid-instruction and in HALT; no partial write SHALL complete after a reset.

Configuration
REQ-033 Macro MC_CONTROL_JAL_EN defined: opcode 0x6F SHALL take path FETCH-DECODE-EXEC with PCWrite=1, PCSel=2, RegWrite=0 in EXEC, and SHALL count as retired.
REQ-034 Macro MC_CONTROL_JAL_EN undefined: opcode 0x6F SHALL be illegal per REQ-029, and PCSel SHALL never be 2.

Verification
REQ-035 rst, run=1, ins=0x00118133 (add) -> IRWrite in cycle 1, op=010 and ALUSrc=0 from cycle 2, RegWrite=1, PCWrite=1 and PCSel=0 in cycle 4; retired=1.
REQ-036 ins=0x00002283 (lw) -> MemRead=1 in cycle 4; RegWrite=1, Mem2Reg=1 and PCWrite=1 in cycle 5; no MemWrite.
REQ-037 ins=0x02802023 (sw) -> MemWrite=1 and PCWrite=1 in cycle 4; RegWrite never 1.
REQ-038 ins=0x00000063 (beq) -> op=110 in EXEC; with zero=1 in cycle 3, PCSel=1; repeated with zero=0, PCSel=0; both cases take 3 cycles.
REQ-039 MAX_INS=3 with three addi (0x00100093) -> done=1 after the third PCWrite, state HALT, retired=3; rst in the middle of the 2nd instruction -> retired=0, FETCH, no RegWrite pulse.
REQ-040 ins=0x0000006F -> with MC_CONTROL_JAL_EN: PCSel=2 in cycle 3; without it: illegal=1, HALT, retired unchanged.
